vga_timing: RTL

Free-running VGA timing generator for the 800x600 @ 60 Hz mode, clocked at 40 MHz. It produces horizontal and vertical pixel counters, sync and blanking strobes, and a frame-start pulse. These are the first stage of the video pipeline and feed the background and mouse drawing stages. All timing values come from the shared `vga_pkg`; this block declares no timing numbers of its own.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing.sv | 70 +++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants for the 800x600 @ 60 Hz, 40 MHz video pipeline.
package vga_pkg;

    localparam int unsigned H_Tot_time   = 1056;
    localparam int unsigned H_Blank_time = 800;
    localparam int unsigned H_Sync_start = 840;
    localparam int unsigned H_Back_time  = 968;

    localparam int unsigned V_Tot_time   = 628;
    localparam int unsigned V_Blank_time = 600;
    localparam int unsigned V_Sync_start = 601;
    localparam int unsigned V_Back_time  = 605;

    localparam int unsigned COUNT_W = 11;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus registered sync/blank
// strobes derived from the next-state count so they never skew.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL       = H_Tot_time,
    parameter int unsigned BLANK_START = H_Blank_time,
    parameter int unsigned SYNC_START  = H_Sync_start,
    parameter int unsigned SYNC_END    = H_Back_time
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    output logic [COUNT_W-1:0] count,
    output logic               sync,
    output logic               blnk,
    output logic               wrap_out
);

    localparam logic [COUNT_W-1:0] LAST   = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] BLANK  = COUNT_W'(BLANK_START);
    localparam logic [COUNT_W-1:0] SYNC_S = COUNT_W'(SYNC_START);
    localparam logic [COUNT_W-1:0] SYNC_E = COUNT_W'(SYNC_END);

    logic [COUNT_W-1:0] count_d, count_q;
    logic               sync_d, sync_q;
    logic               blnk_d, blnk_q;
    logic               at_last;

    assign at_last  = (count_q == LAST);
    assign wrap_out = inc && at_last;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
        sync_d = (count_d >= SYNC_S) && (count_d < SYNC_E);
        blnk_d = (count_d >= BLANK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sync_q  <= 1'b0;
            blnk_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            blnk_q  <= blnk_d;
        end
    end

    assign count = count_q;
    assign sync  = sync_q;
    assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing.sv
// Free-running 800x600 VGA timing generator: H axis chained into V axis,
// with a registered one-cycle frame_start on the (1055,627)->(0,0) wrap.
module vga_timing
    import vga_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               hblnk,
    output logic               vblnk,
    output logic               frame_start
);

    logic h_wrap;
    logic v_wrap;
    logic frame_start_d, frame_start_q;

    vga_axis_counter #(
        .TOTAL      (H_Tot_time),
        .BLANK_START(H_Blank_time),
        .SYNC_START (H_Sync_start),
        .SYNC_END   (H_Back_time)
    ) u_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (en),
        .count   (hcount),
        .sync    (hsync),
        .blnk    (hblnk),
        .wrap_out(h_wrap)
    );

    vga_axis_counter #(
        .TOTAL      (V_Tot_time),
        .BLANK_START(V_Blank_time),
        .SYNC_START (V_Sync_start),
        .SYNC_END   (V_Back_time)
    ) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (h_wrap),
        .count   (vcount),
        .sync    (vsync),
        .blnk    (vblnk),
        .wrap_out(v_wrap)
    );

    // v_wrap already implies h_wrap; held while en is low
    always_comb begin
        frame_start_d = frame_start_q;
        if (en) begin
            frame_start_d = v_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

endmodule
